// File: rtl/srpt_grant_pkt_queue.sv
// rtl/srpt_grant_pkt_queue.sv - Homa receiver SRPT grant scheduler over a table of active inbound messages
// Optional rank-based grant priority is enabled by defining SRPT_GRANT_PRIO_EN.
module srpt_grant_pkt_queue #(
    parameter int MAX_ENTRIES = 16,
    parameter int RTT_BYTES   = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_ce,
    input  logic        ap_start,
    input  logic        ap_continue,
    output logic        ap_idle,
    output logic        ap_done,
    output logic        ap_ready,
    input  logic        header_in_empty_i,
    output logic        header_in_read_en_o,
    input  logic [57:0] header_in_data_i,
    input  logic        grant_pkt_full_o,
    output logic        grant_pkt_write_en_o,
    output logic [50:0] grant_pkt_data_o
);
    localparam int          IW  = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
    localparam logic [10:0] RTT = 11'(RTT_BYTES);

    logic [13:0] h_peer, h_rpc;
    logic [9:0]  h_len, h_inc, h_off;
    assign {h_peer, h_rpc, h_len, h_inc, h_off} = header_in_data_i;

    logic [MAX_ENTRIES-1:0] slot_valid;
    logic [13:0]            slot_peer    [MAX_ENTRIES];
    logic [13:0]            slot_rpc     [MAX_ENTRIES];
    logic [9:0]             slot_len     [MAX_ENTRIES];
    logic [9:0]             slot_rcvd    [MAX_ENTRIES];
    logic [9:0]             slot_granted [MAX_ENTRIES];

    logic unused_continue;
    assign unused_continue = ap_continue;

    // Strobes are gated by reset so they read zero the moment reset asserts.
    logic active;
    assign active = ap_start & ap_ce & ~ap_rst;

    logic          hit, free_found;
    logic [IW-1:0] hit_idx, free_idx;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (slot_valid[i] && (slot_rpc[i] == h_rpc)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        // Scan downwards so the lowest free index is the one left standing.
        for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    logic [MAX_ENTRIES-1:0] elig;
    logic [9:0]             rem   [MAX_ENTRIES];
    logic [10:0]            reach [MAX_ENTRIES];

    always_comb begin
        elig = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            reach[i] = {1'b0, slot_rcvd[i]} + RTT;
            rem[i]   = slot_len[i] - slot_rcvd[i];
            elig[i]  = slot_valid[i] && (slot_granted[i] < slot_len[i])
                       && ({1'b0, slot_granted[i]} < reach[i]);
        end
    end

    logic          any_elig;
    logic [IW-1:0] sel;
    logic [9:0]    best_rem;

    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        best_rem = '1;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (elig[i] && (!any_elig || (rem[i] < best_rem))) begin
                any_elig = 1'b1;
                sel      = IW'(i);
                best_rem = rem[i];
            end
        end
    end

    logic [10:0] sel_reach;
    logic [9:0]  grant_off;
    logic        grant_last;

    assign sel_reach  = reach[sel];
    assign grant_off  = (sel_reach < {1'b0, slot_len[sel]}) ? sel_reach[9:0] : slot_len[sel];
    assign grant_last = (grant_off == slot_len[sel]);

    logic [2:0] prio;
`ifdef SRPT_GRANT_PRIO_EN
    int rank;
    always_comb begin
        rank = 0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (slot_valid[i] && (rem[i] < best_rem)) rank = rank + 1;
        end
        prio = (rank > 7) ? 3'd7 : 3'(rank);
    end
`else
    assign prio = 3'b000;
`endif

    assign header_in_read_en_o  = active & ~header_in_empty_i & (hit | free_found);
    assign grant_pkt_write_en_o = active & ~grant_pkt_full_o & any_elig;
    assign grant_pkt_data_o     = any_elig ? {slot_peer[sel], slot_rpc[sel], slot_len[sel], grant_off, prio}
                                           : 51'd0;
    assign ap_done  = header_in_read_en_o;
    assign ap_ready = header_in_read_en_o;
    assign ap_idle  = ~ap_start & ~(|slot_valid);

    // Grant targets a valid slot and allocation a free one, so their writes never collide.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            slot_valid <= '0;
            for (int i = 0; i < MAX_ENTRIES; i++) begin
                slot_peer[i]    <= '0;
                slot_rpc[i]     <= '0;
                slot_len[i]     <= '0;
                slot_rcvd[i]    <= '0;
                slot_granted[i] <= '0;
            end
        end else begin
            if (grant_pkt_write_en_o) begin
                slot_granted[sel] <= grant_off;
                if (grant_last) slot_valid[sel] <= 1'b0;
            end
            if (header_in_read_en_o) begin
                if (hit) begin
                    if (h_off > slot_rcvd[hit_idx]) slot_rcvd[hit_idx] <= h_off;
                end else begin
                    slot_valid[free_idx]   <= 1'b1;
                    slot_peer[free_idx]    <= h_peer;
                    slot_rpc[free_idx]     <= h_rpc;
                    slot_len[free_idx]     <= h_len;
                    slot_rcvd[free_idx]    <= h_off;
                    slot_granted[free_idx] <= h_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_srpt_grant_pkt_queue.sv
// tb/tb_srpt_grant_pkt_queue.sv - randomized, model-checked bench for srpt_grant_pkt_queue
module tb_srpt_grant_pkt_queue;
    localparam int N   = 16;
    localparam int RTT = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_ce, ap_start, ap_continue;
    logic        ap_idle, ap_done, ap_ready;
    logic        header_in_empty_i, header_in_read_en_o;
    logic [57:0] header_in_data_i;
    logic        grant_pkt_full_o, grant_pkt_write_en_o;
    logic [50:0] grant_pkt_data_o;

    srpt_grant_pkt_queue #(.MAX_ENTRIES(N), .RTT_BYTES(RTT)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
        .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
        .header_in_empty_i(header_in_empty_i), .header_in_read_en_o(header_in_read_en_o),
        .header_in_data_i(header_in_data_i), .grant_pkt_full_o(grant_pkt_full_o),
        .grant_pkt_write_en_o(grant_pkt_write_en_o), .grant_pkt_data_o(grant_pkt_data_o)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        bit       v;
        bit [13:0] peer;
        bit [13:0] rpc;
        bit [9:0]  len;
        bit [9:0]  rcvd;
        bit [9:0]  gr;
    } slot_t;

    int          total = 0;
    int          bad   = 0;
    slot_t       m [N];
    logic [57:0] fifo [$];
    logic [50:0] glog [$];
    logic [50:0] mlog [$];
    int          rd_cnt, wr_cnt;

    bit          e_rd, e_wr, e_idle;
    logic [50:0] e_data;
    int          e_hit, e_free, e_sel;
    bit [9:0]    e_goff;
    bit          s_rd, s_wr;
    logic [50:0] s_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [57:0] hdr(input int rpc, input int peer, input int len,
                                         input int inc, input int off);
        return {14'(peer), 14'(rpc), 10'(len), 10'(inc), 10'(off)};
    endfunction

    task automatic drive_fifo();
        header_in_empty_i = (fifo.size() == 0);
        header_in_data_i  = (fifo.size() != 0) ? fifo[0] : 58'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m[i] = '{0, 0, 0, 0, 0, 0};
    endtask

    // Expected outputs for the current cycle, straight from the scheduling rules.
    task automatic model_eval();
        bit        act, any_valid;
        bit [13:0] h_rpc;
        bit [9:0]  r, rsel;
        int        key, best, reach, cnt;
        act   = ap_start && ap_ce && !ap_rst;
        h_rpc = header_in_data_i[43:30];
        e_hit = -1; e_free = -1; e_sel = -1; best = 1 << 30; any_valid = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i].v) any_valid = 1;
            if (m[i].v && m[i].rpc == h_rpc) e_hit = i;
            if (!m[i].v && e_free < 0) e_free = i;
            if (m[i].v && m[i].gr < m[i].len && int'(m[i].gr) < int'(m[i].rcvd) + RTT) begin
                r   = m[i].len - m[i].rcvd;
                key = int'(r) * N + i;
                if (key < best) begin best = key; e_sel = i; end
            end
        end
        e_rd   = act && !header_in_empty_i && (e_hit >= 0 || e_free >= 0);
        e_wr   = act && !grant_pkt_full_o && (e_sel >= 0);
        e_idle = !ap_start && !any_valid;
        e_data = '0;
        e_goff = '0;
        if (e_sel >= 0) begin
            reach  = int'(m[e_sel].rcvd) + RTT;
            e_goff = (reach < int'(m[e_sel].len)) ? 10'(reach) : m[e_sel].len;
            cnt    = 0;
`ifdef SRPT_GRANT_PRIO_EN
            rsel = m[e_sel].len - m[e_sel].rcvd;
            for (int j = 0; j < N; j++) begin
                r = m[j].len - m[j].rcvd;
                if (m[j].v && r < rsel) cnt++;
            end
            if (cnt > 7) cnt = 7;
`else
            rsel = '0;
`endif
            e_data = {m[e_sel].peer, m[e_sel].rpc, m[e_sel].len, e_goff, 3'(cnt)};
        end
    endtask

    task automatic model_commit();
        bit [9:0] off;
        if (ap_rst) begin model_clear(); return; end
        if (e_wr) begin
            m[e_sel].gr = e_goff;
            if (e_goff == m[e_sel].len) m[e_sel].v = 0;
        end
        if (e_rd) begin
            off = header_in_data_i[9:0];
            if (e_hit >= 0) begin
                if (off > m[e_hit].rcvd) m[e_hit].rcvd = off;
            end else begin
                m[e_free] = '{1, header_in_data_i[57:44], header_in_data_i[43:30],
                              header_in_data_i[29:20], off, header_in_data_i[19:10]};
            end
        end
    endtask

    task automatic tick();
        @(negedge ap_clk);
        model_eval();
        s_rd = header_in_read_en_o; s_wr = grant_pkt_write_en_o; s_data = grant_pkt_data_o;
        chk("read_en", s_rd, e_rd);
        chk("write_en", s_wr, e_wr);
        chk("done", ap_done, e_rd);
        chk("ready", ap_ready, e_rd);
        chk("idle", ap_idle, e_idle);
        chk("grant_data", s_data, e_data);
        if (s_rd) rd_cnt++;
        if (s_wr) begin wr_cnt++; glog.push_back(s_data); end
        if (e_wr) mlog.push_back(e_data);
        @(posedge ap_clk);
        model_commit();
        if (s_rd && fifo.size() != 0) void'(fifo.pop_front());
        #1;
        drive_fifo();
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        model_clear();
        #1;
        chk("rst_read_en", header_in_read_en_o, 0);
        chk("rst_write_en", grant_pkt_write_en_o, 0);
        chk("rst_done", ap_done, 0);
        chk("rst_data", grant_pkt_data_o, 0);
        tick();
        ap_rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit && fifo.size() != 0; k++) tick();
        chk("fifo_drained", fifo.size(), 0);
    endtask

    int exp_rpc [5] = '{1, 2, 3, 4, 5};
    int exp_off [5] = '{1, 2, 3, 4, 4};

    initial begin
        ap_rst = 1'b1; ap_ce = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
        grant_pkt_full_o = 1'b0;
        model_clear();
        drive_fifo();
        #2;
        chk("reset_read_en", header_in_read_en_o, 0);
        chk("reset_write_en", grant_pkt_write_en_o, 0);
        chk("reset_done", ap_done, 0);
        chk("reset_ready", ap_ready, 0);
        chk("reset_data", grant_pkt_data_o, 0);
        chk("reset_idle", ap_idle, 1);
        tick(); tick();
        ap_rst = 1'b0;

        // Five headers with the output held full: all consumed, nothing granted.
        ap_start = 1'b1; grant_pkt_full_o = 1'b1; rd_cnt = 0; wr_cnt = 0;
        fifo.push_back(hdr(5, 5, 5, 0, 0));
        fifo.push_back(hdr(4, 4, 4, 0, 0));
        fifo.push_back(hdr(3, 3, 3, 0, 0));
        fifo.push_back(hdr(1, 1, 1, 0, 0));
        fifo.push_back(hdr(2, 2, 2, 0, 0));
        drive_fifo();
        drain(20);
        tick(); tick();
        chk("p1_reads", rd_cnt, 5);
        chk("p1_writes", wr_cnt, 0);
        chk("p1_idle", ap_idle, 0);

        // Release the output: SRPT order by remaining length.
        glog.delete(); mlog.delete();
        grant_pkt_full_o = 1'b0;
        repeat (8) tick();
        chk("p2_count", glog.size(), 5);
        chk("p2_model_count", mlog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            chk("p2_rpc", glog[i][36:23], exp_rpc[i]);
            chk("p2_off", glog[i][12:3], exp_off[i]);
        end
        for (int i = 0; i < 5 && i < mlog.size(); i++) chk("p2_model_off", mlog[i][12:3], exp_off[i]);

        // rpc 5 advances its received offset and finishes.
        glog.delete();
        fifo.push_back(hdr(5, 5, 5, 0, 4));
        drive_fifo();
        repeat (4) tick();
        chk("p3_count", glog.size(), 1);
        if (glog.size() != 0) chk("p3_off", glog[0][12:3], 5);
        ap_start = 1'b0;
        #1;
        chk("p3_idle", ap_idle, 1);
        ap_start = 1'b1;

        // New peers with lengths seen before get their own slots.
        glog.delete();
        fifo.push_back(hdr(6, 3, 3, 0, 0));
        fifo.push_back(hdr(7, 4, 4, 0, 0));
        drive_fifo();
        repeat (6) tick();
        chk("p4_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("p4_first_rpc", glog[0][36:23], 6);
            chk("p4_first_off", glog[0][12:3], 3);
            chk("p4_second_rpc", glog[1][36:23], 7);
            chk("p4_second_off", glog[1][12:3], 4);
        end

        // Fill every slot, then a further rpc must stall until one frees.
        grant_pkt_full_o = 1'b1;
        for (int i = 0; i < N; i++) fifo.push_back(hdr(10 + i, i, 1, 0, 0));
        drive_fifo();
        drain(30);
        fifo.push_back(hdr(30, 30, 2, 0, 0));
        drive_fifo();
        repeat (3) begin
            tick();
            chk("p5_stall", s_rd, 0);
        end
        grant_pkt_full_o = 1'b0;
        tick();
        chk("p5_grant_first", s_wr, 1);
        chk("p5_no_read_yet", s_rd, 0);
        tick();
        chk("p5_read_next", s_rd, 1);

        // Clock enable low freezes everything; then reset mid-stream.
        fifo.push_back(hdr(40, 1, 5, 0, 0));
        ap_ce = 1'b0;
        drive_fifo();
        repeat (3) begin
            tick();
            chk("p6_ce_read", s_rd, 0);
            chk("p6_ce_write", s_wr, 0);
        end
        ap_ce = 1'b1;
        tick();
        #2;
        do_reset();
        ap_start = 1'b0;
        #1;
        chk("p6_idle_after_reset", ap_idle, 1);
        fifo.delete();
        drive_fifo();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int rpc, len;
            ap_start         = ($urandom % 10) != 0;
            ap_ce            = ($urandom % 8) != 0;
            ap_continue      = $urandom % 2;
            grant_pkt_full_o = ($urandom % 3) == 0;
            if (($urandom % 3) == 0 && fifo.size() < 4) begin
                rpc = $urandom % 24;
                len = (rpc % 13) + 3;
                fifo.push_back(hdr(rpc, $urandom % 16384, len,
                                   $urandom_range(0, len - 1), $urandom_range(0, len)));
            end
            drive_fifo();
            if (($urandom % 400) == 0) do_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
